qr_stream_adapter: RTL and testbench
====================================

Name: qr_stream_adapter

Overview:
- Bridges an element-serial valid/ready stream to the row-parallel load and transfer interface of the QR solver core.
- Collects one MATRIX_SIZE x MATRIX_SIZE matrix A in row-major order and bursts it to the solver as R rows, each paired with the matching column of an identity Q.
- Captures the solver's R and Q transfer burst, then replays it element-serially to the downstream consumer.

Parameters:
- INT_LEN, 5, integer bits per fixed-point element (two's complement).
- FRAC_LEN, 19, fractional bits per element; WORD = INT_LEN+FRAC_LEN.
- MATRIX_SIZE, 4, matrix dimension N; ROW_W = N*WORD.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only when QR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- nRst  in  1  reset: synchronous, active-low; clock clk.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accepted when s_valid&&s_ready.
- s_data  in  WORD  A element, row-major.
- qr_input_valid  out  1  row beat to solver.
- qr_row_r  out  ROW_W  R row k.
- qr_col_q  out  ROW_W  identity Q column k.
- qr_transfer_valid  in  1  solver result row beat.
- qr_row_r_in  in  ROW_W  result R row.
- qr_col_q_in  in  ROW_W  result Q column.
- m_valid  out  1  output element valid.
- m_ready  in  1  output handshake.
- m_data  out  WORD  output element.
- m_sel  out  1  0 = R element, 1 = Q element.
- m_last  out  1  final element of the result set.
- busy  out  1  high whenever state != LOAD.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Packing: element j of a row occupies bits [ROW_W-1-j*WORD -: WORD]; element 0 is in the most significant slice.
- Buffers: rbuf[0..N-1] and qbuf[0..N-1], each ROW_W wide. They are reused for load and capture and are not cleared by reset.
- Reset values: state=LOAD; all counters 0; s_ready=1; qr_input_valid=0; qr_row_r=0; qr_col_q=0; m_valid=0; m_data=0; m_sel=0; m_last=0; busy=0; timeout_err=0.
- LOAD:
  - s_ready=1.
  - Each handshake writes s_data into rbuf[row][col]; col increments and wraps at N-1 to 0, then row increments.
  - On acceptance of element N*N-1, go to SEND. s_ready is 0 from the following cycle.
  - Gaps in s_valid are tolerated.
- SEND:
  - Registered outputs. qr_input_valid=1 for exactly N consecutive cycles, starting the cycle after the last element is accepted.
  - Beat k drives qr_row_r=rbuf[k] and qr_col_q = identity column k: element k = 1<<FRAC_LEN, all other elements 0.
  - After the Nth beat: qr_input_valid=0, qr_row_r=0, qr_col_q=0, go to WAIT.
- WAIT:
  - Wait for qr_transfer_valid.
  - A beat arriving in the same cycle as the WAIT->CAPTURE transition is captured as row 0; no beat is lost.
- CAPTURE:
  - Each cycle with qr_transfer_valid=1: rbuf[cnt]<=qr_row_r_in, qbuf[cnt]<=qr_col_q_in, cnt++.
  - If qr_transfer_valid drops before N beats, stay in CAPTURE and keep the current count.
  - After the Nth beat, go to DRAIN.
  - qr_transfer_valid is ignored in LOAD, SEND and DRAIN.
- DRAIN:
  - m_valid=1. Emits N*N R elements (row-major from rbuf, m_sel=0), then N*N Q elements (row-major from qbuf, m_sel=1).
  - Index advances only on m_valid&&m_ready; m_data, m_sel and m_last hold stable while stalled.
  - m_last=1 only on element 2N*N-1.
  - After the final handshake: m_valid=0, return to LOAD, s_ready=1 on the next cycle.
- Latency:
  - Last input element to first qr_input_valid: 1 cycle.
  - Nth capture beat to first m_valid: 1 cycle.
- Reset mid-operation: every output and counter returns to its reset value on the next clk edge; any partial matrix is discarded.

Optional Feature:
- Macro: QR_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and CAPTURE and resets on every qr_transfer_valid beat.
  - When it reaches TIMEOUT_CYCLES: timeout_err<=1 (sticky until nRst), the partial capture is discarded, and the block returns to LOAD without draining.
- Undefined: no counter is built; timeout_err is tied to 0; the block waits indefinitely.

Test Plan:
- Identity A (N=4, FRAC_LEN=19; diagonal 0x80000) streamed back-to-back -> qr_input_valid high for 4 cycles, starting 1 cycle after the 16th element. Beat 0: qr_row_r=qr_col_q={0x80000,0,0,0}; beat 3: element 3 = 0x80000.
- Solver model returns rows R_i with element j = 16*i+j and Q with element j = 0x100+16*i+j over 4 consecutive beats -> 32 outputs in order 0x00..0x33 (m_sel=0), then 0x100..0x133 (m_sel=1); m_last only on 0x133.
- m_ready toggling 1,0,0,1 and s_valid with random gaps -> no lost or duplicated elements; m_data stable while stalled.
- qr_transfer_valid pattern 1,1,0,0,1,1 -> exactly 4 rows captured in order; DRAIN entered after the 6th cycle.
- nRst low for 1 cycle mid-DRAIN (element 10) -> m_valid=0, s_ready=1, busy=0; a fresh matrix then processes correctly.
- QR_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no transfer after SEND -> timeout_err=1 after 16 WAIT cycles; back in LOAD with s_ready=1; flag stays set until reset.

Source files
------------

// File: rtl/qr_stream_adapter.sv
// Purpose: element-serial stream <-> row-parallel QR solver bridge (load A, burst rows + identity Q, capture R/Q, replay serially).
// Latency: last input element -> first qr_input_valid 1 cycle; Nth capture beat -> first m_valid 1 cycle.
// Backpressure: s_ready is high only in LOAD; drain index advances only on m_valid&&m_ready, outputs hold while stalled.
// Optional: define QR_TIMEOUT_EN to build the WAIT/CAPTURE watchdog (timeout_err is tied low otherwise).
module qr_stream_adapter #(
  parameter int INT_LEN        = 5,
  parameter int FRAC_LEN       = 19,
  parameter int MATRIX_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                          clk,
  input  logic                                          nRst,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [INT_LEN+FRAC_LEN-1:0]                   s_data,
  output logic                                          qr_input_valid,
  output logic [MATRIX_SIZE*(INT_LEN+FRAC_LEN)-1:0]     qr_row_r,
  output logic [MATRIX_SIZE*(INT_LEN+FRAC_LEN)-1:0]     qr_col_q,
  input  logic                                          qr_transfer_valid,
  input  logic [MATRIX_SIZE*(INT_LEN+FRAC_LEN)-1:0]     qr_row_r_in,
  input  logic [MATRIX_SIZE*(INT_LEN+FRAC_LEN)-1:0]     qr_col_q_in,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [INT_LEN+FRAC_LEN-1:0]                   m_data,
  output logic                                          m_sel,
  output logic                                          m_last,
  output logic                                          busy,
  output logic                                          timeout_err
);

  localparam int WORD  = INT_LEN + FRAC_LEN;
  localparam int N     = MATRIX_SIZE;
  localparam int NN    = N * N;
  localparam int ROW_W = N * WORD;
  localparam int IW    = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam int DW    = $clog2(2 * NN);

  localparam logic [IW-1:0] LAST_RC  = IW'(N - 1);
  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [DW-1:0] IDX_LAST = DW'(2 * NN - 1);

  typedef enum logic [2:0] {LOAD, SEND, WAIT, CAPTURE, DRAIN} state_t;

  state_t           state;
  logic [IW-1:0]    load_row;
  logic [IW-1:0]    load_col;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    drain_idx;
  logic             to_fire;

  // Shared by load and capture; contents are don't-care until written.
  logic [ROW_W-1:0] rbuf [N];
  logic [ROW_W-1:0] qbuf [N];

  int               nxt_e;
  int               nxt_w;
  logic [IW-1:0]    nxt_row;
  logic [IW-1:0]    nxt_col;
  logic             nxt_sel;
  logic             nxt_last;
  logic [WORD-1:0]  nxt_data;

  // Identity column k: fixed-point 1.0 in element k, zero elsewhere.
  function automatic logic [ROW_W-1:0] ident_col(input logic [IW-1:0] k);
    logic [ROW_W-1:0] c;
    c = '0;
    c[ROW_W-1-int'(k)*WORD -: WORD] = WORD'(1) << FRAC_LEN;
    return c;
  endfunction

  // Look up the element that follows the one currently presented on m_data.
  always_comb begin
    nxt_e = int'(drain_idx) + 1;
    if (nxt_e >= 2 * NN) nxt_e = 0;
    nxt_sel  = (nxt_e >= NN);
    nxt_w    = nxt_sel ? (nxt_e - NN) : nxt_e;
    nxt_row  = IW'(nxt_w / N);
    nxt_col  = IW'(nxt_w % N);
    nxt_last = (nxt_e == 2 * NN - 1);
    nxt_data = nxt_sel ? qbuf[nxt_row][ROW_W-1-int'(nxt_col)*WORD -: WORD]
                       : rbuf[nxt_row][ROW_W-1-int'(nxt_col)*WORD -: WORD];
  end

`ifdef QR_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_err;

  assign to_fire = ((state == WAIT) || (state == CAPTURE)) && !qr_transfer_valid && (to_cnt == TO_LAST);
  assign timeout_err = to_err;

  // Watchdog: counts idle solver cycles while waiting for results; any beat restarts it.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (((state == WAIT) || (state == CAPTURE)) && !qr_transfer_valid && !to_fire)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
      if (to_fire)
        to_err <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main sequencer: load, burst to solver, capture results, drain serially.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state          <= LOAD;
      load_row       <= '0;
      load_col       <= '0;
      cnt            <= '0;
      drain_idx      <= '0;
      s_ready        <= 1'b1;
      qr_input_valid <= 1'b0;
      qr_row_r       <= '0;
      qr_col_q       <= '0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_sel          <= 1'b0;
      m_last         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (s_valid && s_ready) begin
            rbuf[load_row][ROW_W-1-int'(load_col)*WORD -: WORD] <= s_data;
            if (load_col == LAST_RC) begin
              load_col <= '0;
              if (load_row == LAST_RC) begin
                // Final element: row 0 goes out on the very next cycle.
                load_row       <= '0;
                state          <= SEND;
                s_ready        <= 1'b0;
                busy           <= 1'b1;
                qr_input_valid <= 1'b1;
                qr_row_r       <= (N == 1) ? ROW_W'(s_data) : rbuf[0];
                qr_col_q       <= ident_col('0);
                cnt            <= CW'(1);
              end else begin
                load_row <= load_row + IW'(1);
              end
            end else begin
              load_col <= load_col + IW'(1);
            end
          end
        end
        SEND: begin
          if (cnt == CNT_N) begin
            qr_input_valid <= 1'b0;
            qr_row_r       <= '0;
            qr_col_q       <= '0;
            cnt            <= '0;
            state          <= WAIT;
          end else begin
            qr_row_r <= rbuf[cnt[IW-1:0]];
            qr_col_q <= ident_col(cnt[IW-1:0]);
            cnt      <= cnt + CW'(1);
          end
        end
        WAIT, CAPTURE: begin
          if (qr_transfer_valid) begin
            // WAIT captures its first beat directly, so no beat is lost on entry.
            rbuf[cnt[IW-1:0]] <= qr_row_r_in;
            qbuf[cnt[IW-1:0]] <= qr_col_q_in;
            if (cnt == CNT_LAST) begin
              cnt       <= '0;
              state     <= DRAIN;
              drain_idx <= '0;
              m_valid   <= 1'b1;
              m_data    <= (N == 1) ? qr_row_r_in[ROW_W-1 -: WORD] : rbuf[0][ROW_W-1 -: WORD];
              m_sel     <= 1'b0;
              m_last    <= 1'b0;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= CAPTURE;
            end
          end else if (to_fire) begin
            cnt     <= '0;
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        DRAIN: begin
          if (m_valid && m_ready) begin
            if (drain_idx == IDX_LAST) begin
              m_valid   <= 1'b0;
              m_data    <= '0;
              m_sel     <= 1'b0;
              m_last    <= 1'b0;
              drain_idx <= '0;
              state     <= LOAD;
              s_ready   <= 1'b1;
              busy      <= 1'b0;
            end else begin
              drain_idx <= drain_idx + DW'(1);
              m_data    <= nxt_data;
              m_sel     <= nxt_sel;
              m_last    <= nxt_last;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_qr_stream_adapter.sv
// Bench for qr_stream_adapter (default build, N=4, FRAC_LEN=19).
// Table-driven drain vectors plus directed load/send/capture/reset sequences.
module tb_qr_stream_adapter;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        qr_input_valid;
  logic [95:0] qr_row_r;
  logic [95:0] qr_col_q;
  logic        qr_transfer_valid = 1'b0;
  logic [95:0] qr_row_r_in = '0;
  logic [95:0] qr_col_q_in = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sel;
  logic        m_last;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  qr_stream_adapter dut (
    .clk(clk), .nRst(nRst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .qr_input_valid(qr_input_valid), .qr_row_r(qr_row_r), .qr_col_q(qr_col_q),
    .qr_transfer_valid(qr_transfer_valid), .qr_row_r_in(qr_row_r_in), .qr_col_q_in(qr_col_q_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sel(m_sel), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          rdy;   // m_ready applied this cycle
    int          idx;   // element index expected on the output
    logic [23:0] data;
    bit          sel;
    bit          last;
  } dvec_t;

  dvec_t       tab_full[$];
  dvec_t       tab_stall[$];
  logic [23:0] mat_id[16];
  logic [23:0] mat_b[16];
  logic [23:0] cur[16];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_row(input int base, input int i);
    logic [95:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[95-24*j -: 24] = 24'(base + 16*i + j);
    return r;
  endfunction

  function automatic logic [95:0] pack_row(input int k);
    logic [95:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[95-24*j -: 24] = cur[4*k+j];
    return r;
  endfunction

  function automatic logic [95:0] ident(input int k);
    logic [95:0] r;
    r = '0;
    r[95-24*k -: 24] = 24'h080000;
    return r;
  endfunction

  // Expected drain sequence for a repeating 4-cycle m_ready pattern (bit c = cycle c).
  task automatic build_drain(input bit [3:0] pat, output dvec_t t[$]);
    int idx = 0;
    int c = 0;
    t.delete();
    while (idx < 32) begin
      dvec_t v;
      v.rdy  = pat[c % 4];
      v.idx  = idx;
      v.sel  = (idx >= 16);
      v.last = (idx == 31);
      v.data = (idx < 16) ? 24'(16*(idx/4) + idx%4) : 24'(256 + 16*((idx-16)/4) + (idx-16)%4);
      t.push_back(v);
      if (v.rdy) idx++;
      c++;
    end
  endtask

  // Called at a negedge; drives elements of cur with optional idle gaps.
  task automatic push_matrix(input bit gaps, input int count, input string tag);
    for (int e = 0; e < count; e++) begin
      int n = 0;
      if (gaps) begin
        int g = $urandom_range(0, 2);
        s_valid = 1'b0;
        s_data  = 24'hDEAD00;
        repeat (g) @(negedge clk);
      end
      if (e == 15) check({tag, "_pre_send_valid"}, qr_input_valid, 1'b0);
      s_valid = 1'b1;
      s_data  = cur[e];
      while (!s_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_s_ready"}, s_ready, 1'b1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Entered at the negedge right after the last element was accepted.
  task automatic check_send(input bit junk_xfer, input string tag);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_qr_input_valid"}, qr_input_valid, 1'b1);
      check({tag, "_qr_row_r"}, qr_row_r, pack_row(k));
      check({tag, "_qr_col_q"}, qr_col_q, ident(k));
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_s_ready_low"}, s_ready, 1'b0);
      if (junk_xfer) begin
        qr_transfer_valid = 1'b1;
        qr_row_r_in = {4{24'hABCDEF}};
        qr_col_q_in = {4{24'h123456}};
      end
      @(negedge clk);
    end
    qr_transfer_valid = 1'b0;
    check({tag, "_send_done_valid"}, qr_input_valid, 1'b0);
    check({tag, "_send_done_row"}, qr_row_r, 96'h0);
    check({tag, "_send_done_col"}, qr_col_q, 96'h0);
  endtask

  // Solver model: beat i returns R elements 16*i+j and Q elements 0x100+16*i+j.
  task automatic solver(input bit [5:0] pat, input int ncyc, input string tag);
    int beat = 0;
    for (int c = 0; c < ncyc; c++) begin
      qr_transfer_valid = pat[c];
      qr_row_r_in = pat[c] ? mk_row(0, beat)   : {4{24'hBADBAD}};
      qr_col_q_in = pat[c] ? mk_row(256, beat) : {4{24'hBADBAD}};
      @(negedge clk);
      if (pat[c]) beat++;
      if (beat < 4) check({tag, "_no_early_m_valid"}, m_valid, 1'b0);
    end
    qr_transfer_valid = 1'b0;
    qr_row_r_in = '0;
    qr_col_q_in = '0;
    check({tag, "_drain_latency"}, m_valid, 1'b1);
  endtask

  // Applies a drain table; stops (m_ready low) once element stop_at is presented.
  task automatic run_drain(input bit stall, input int stop_at, input string tag);
    dvec_t t[$];
    if (stall) t = tab_stall;
    else       t = tab_full;
    foreach (t[k]) begin
      check({tag, "_m_valid"}, m_valid, 1'b1);
      check({tag, "_m_data"}, m_data, t[k].data);
      check({tag, "_m_sel"}, m_sel, t[k].sel);
      check({tag, "_m_last"}, m_last, t[k].last);
      if (t[k].idx == stop_at) begin
        m_ready = 1'b0;
        return;
      end
      m_ready = t[k].rdy;
      @(negedge clk);
    end
    m_ready = 1'b0;
    check({tag, "_end_m_valid"}, m_valid, 1'b0);
    check({tag, "_end_m_last"}, m_last, 1'b0);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_s_ready"}, s_ready, 1'b1);
  endtask

  initial begin
    build_drain(4'b1111, tab_full);
    build_drain(4'b1001, tab_stall);
    for (int e = 0; e < 16; e++) begin
      mat_id[e] = (e / 4 == e % 4) ? 24'h080000 : 24'h000000;
      mat_b[e]  = 24'(32'hF00000 + e * 273);
    end

    // Reset state
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_qr_input_valid", qr_input_valid, 1'b0);
    check("rst_qr_row_r", qr_row_r, 96'h0);
    check("rst_qr_col_q", qr_col_q, 96'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 24'h0);
    check("rst_m_sel", m_sel, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    nRst = 1'b1;

    // Identity A back-to-back; junk transfer beats during SEND must be ignored
    cur = mat_id;
    push_matrix(1'b0, 16, "id");
    check_send(1'b1, "id");
    for (int i = 0; i < 3; i++) begin
      check("wait_m_valid", m_valid, 1'b0);
      check("wait_busy", busy, 1'b1);
      check("wait_s_ready", s_ready, 1'b0);
      @(negedge clk);
    end
    solver(6'b001111, 4, "xfer4");
    run_drain(1'b0, 99, "drain_full");

    // Gapped input, gapped transfer beats, stalled drain
    cur = mat_b;
    push_matrix(1'b1, 16, "gap");
    check_send(1'b0, "gap");
    solver(6'b110011, 6, "xfer_gap");
    run_drain(1'b1, 99, "drain_stall");

    // Reset mid-LOAD discards the partial matrix
    push_matrix(1'b1, 5, "partial");
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    check("rst_load_s_ready", s_ready, 1'b1);
    check("rst_load_busy", busy, 1'b0);
    push_matrix(1'b0, 16, "after_rst");
    check_send(1'b0, "after_rst");
    solver(6'b001111, 4, "xfer_cut");
    run_drain(1'b0, 10, "drain_cut");

    // Reset mid-DRAIN while element 10 is presented
    nRst = 1'b0;
    @(negedge clk);
    check("rst_drain_m_valid", m_valid, 1'b0);
    check("rst_drain_s_ready", s_ready, 1'b1);
    check("rst_drain_busy", busy, 1'b0);
    check("rst_drain_m_data", m_data, 24'h0);
    check("rst_drain_m_last", m_last, 1'b0);
    check("rst_drain_qr_input_valid", qr_input_valid, 1'b0);
    nRst = 1'b1;

    // Fresh matrix after the reset
    cur = mat_id;
    push_matrix(1'b1, 16, "fresh");
    check_send(1'b0, "fresh");
    solver(6'b001111, 4, "xfer_fresh");
    run_drain(1'b1, 99, "drain_fresh");
    check("final_timeout_err", timeout_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
